// File: rtl/nest_checker.sv
// nest_checker
//
// Purpose:
//    Watches an ASCII character stream and checks that block keywords are
//    properly nested.  Characters are folded to lower case, split into words
//    on spaces, and each word is classified by a small word FSM.  The exact
//    word "begin" pushes a type-B entry onto a one-bit type stack and "end"
//    pops one, requiring a type-B entry on top.  The first nesting error is
//    latched and freezes the stack until reset.
//
// Optional feature (macro NEST_CHECKER_CASE_EN):
//    When defined, "case" pushes a type-C entry and "endcase" pops one,
//    requiring type C on top.  When undefined, both are ordinary junk words.
//
// Parameters:
//    DEPTH    maximum nesting depth held (2..256)
//    CW       depth counter width, 2**CW > DEPTH
//
// Ports:
//    clk       in   clock, rising edge active
//    reset     in   asynchronous active-high reset
//    in_valid  in   in carries a character this cycle
//    in        in   8-bit ASCII character
//    balanced  out  registered, 1 when depth is 0 and no error is latched
//    depth     out  registered current nesting depth
//    error     out  registered sticky error flag
//    err_code  out  registered first error: 0 none, 1 underflow,
//                   2 mismatch, 3 overflow
module nest_checker #(
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in,
   output logic          balanced,
   output logic [CW-1:0] depth,
   output logic          error,
   output logic [1:0]    err_code
);

`ifdef NEST_CHECKER_CASE_EN
   localparam int NKW = 4;
`else
   localparam int NKW = 2;
`endif

   localparam int   AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic TYPE_B = 1'b0;
   localparam logic TYPE_C = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      MATCH,
      JUNK
   } state_t;

   state_t           state;
   logic [2:0]       idx;
   logic [NKW-1:0]   mask;
   logic [DEPTH-1:0] stack;

   logic [7:0]       ch;
   logic             is_delim;
   logic [NKW-1:0]   cont;
   logic [NKW-1:0]   hit;
   logic [CW-1:0]    top_idx;
   logic             top_type;
   logic             push_en;
   logic             push_type;
   logic             pop_en;
   logic             pop_type;

   // Keyword table: index 0 "begin", 1 "end", 2 "case", 3 "endcase".
   function automatic int kw_len(input int k);
      case (k)
         0:       kw_len = 5;
         1:       kw_len = 3;
         2:       kw_len = 4;
         3:       kw_len = 7;
         default: kw_len = 0;
      endcase
   endfunction

   function automatic logic [7:0] kw_char(input int k, input int i);
      logic [55:0] s;
      int          len;
      s   = '0;
      len = kw_len(k);
      case (k)
         0:       s = 56'("begin");
         1:       s = 56'("end");
         2:       s = 56'("case");
         3:       s = 56'("endcase");
         default: s = '0;
      endcase
      if (i < len) kw_char = s[8*(len-1-i) +: 8];
      else         kw_char = 8'h00;
   endfunction

   // Per-keyword prefix tracking.  cont says which keywords still match if
   // the current character extends the word; hit says which keyword the
   // word already received equals exactly.  In IDLE idx is 0 and every
   // keyword is a candidate, so the first character is tested the same way.
   // A word of 7 characters can never continue, since no keyword is longer.
   always_comb begin
      ch = in;
      if (in >= 8'h41 && in <= 8'h5A) ch = in | 8'h20;
      is_delim = (in == 8'h20);
      cont = '0;
      hit  = '0;
      for (int k = 0; k < NKW; k++) begin
         cont[k] = ((state == MATCH) ? mask[k] : 1'b1)
                   && (int'(idx) < kw_len(k))
                   && (kw_char(k, int'(idx)) == ch);
         hit[k]  = (state == MATCH) && mask[k] && (int'(idx) == kw_len(k));
      end
      top_idx  = depth - 1'b1;
      top_type = stack[top_idx[AW-1:0]];
`ifdef NEST_CHECKER_CASE_EN
      push_en   = hit[0] | hit[2];
      push_type = hit[2] ? TYPE_C : TYPE_B;
      pop_en    = hit[1] | hit[3];
      pop_type  = hit[3] ? TYPE_C : TYPE_B;
`else
      push_en   = hit[0];
      push_type = TYPE_B;
      pop_en    = hit[1];
      pop_type  = TYPE_B;
`endif
   end

   // Word FSM plus stack and result registers.  A keyword only takes effect
   // on the edge accepting its terminating space, so a trailing word never
   // reaches the stack.  Once error is set the stack side stops changing,
   // while the word FSM keeps tracking words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         mask     <= '0;
         stack    <= '0;
         depth    <= '0;
         balanced <= 1'b1;
         error    <= 1'b0;
         err_code <= 2'd0;
      end else if (in_valid) begin
         case (state)
            IDLE: begin
               if (!is_delim) begin
                  if (|cont) begin
                     state <= MATCH;
                     mask  <= cont;
                     idx   <= 3'd1;
                  end else begin
                     state <= JUNK;
                  end
               end
            end
            MATCH: begin
               if (is_delim) begin
                  state <= IDLE;
                  idx   <= '0;
                  mask  <= '0;
                  if (!error) begin
                     if (push_en) begin
                        if (depth == CW'(DEPTH)) begin
                           error    <= 1'b1;
                           err_code <= 2'd3;
                           balanced <= 1'b0;
                        end else begin
                           stack[depth[AW-1:0]] <= push_type;
                           depth    <= depth + 1'b1;
                           balanced <= 1'b0;
                        end
                     end else if (pop_en) begin
                        if (depth == '0) begin
                           error    <= 1'b1;
                           err_code <= 2'd1;
                           balanced <= 1'b0;
                        end else if (top_type != pop_type) begin
                           error    <= 1'b1;
                           err_code <= 2'd2;
                           balanced <= 1'b0;
                        end else begin
                           depth    <= depth - 1'b1;
                           balanced <= (depth == CW'(1));
                        end
                     end
                  end
               end else if (|cont) begin
                  mask <= cont;
                  idx  <= idx + 3'd1;
               end else begin
                  state <= JUNK;
                  idx   <= '0;
                  mask  <= '0;
               end
            end
            JUNK: begin
               if (is_delim) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
               mask  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/nest_checker.md
NEST_CHECKER -- requirements
Module: nest_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning maximum nesting depth held (2..256).
REQ-002 SHALL have parameter CW, default 5, meaning depth counter width; CW SHALL satisfy 2^CW > DEPTH.
REQ-003 SHALL have port clk  input  1  clock, rising edge active.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in carries a character this cycle.
REQ-006 SHALL have port in  input  8  ASCII character.
REQ-007 SHALL have port balanced  output  1  registered; 1 when depth==0 and no error.
REQ-008 SHALL have port depth  output  CW  registered current nesting depth.
REQ-009 SHALL have port error  output  1  registered sticky error flag.
REQ-010 SHALL have port err_code  output  2  registered first error: 0 none, 1 underflow, 2 mismatch, 3 overflow.

Function
REQ-011 SHALL accept a character only on a rising clk edge with in_valid=1; in_valid=0 SHALL leave all state unchanged.
REQ-012 SHALL fold ASCII 'A'..'Z' to lower case before comparison; all other codes SHALL compare unmodified.
REQ-013 SHALL treat 0x20 (space) as the sole word delimiter; a word is the maximal run of non-delimiter characters.
REQ-014 SHALL run a word FSM with states IDLE (between words), MATCH (current word is a prefix of at least one keyword, char index idx 0..7), JUNK (not a keyword prefix).
REQ-015 IDLE: delimiter -> IDLE; non-delimiter -> MATCH if it equals a keyword's first char, else JUNK.
REQ-016 MATCH: delimiter -> evaluate word, -> IDLE; non-delimiter -> MATCH if word remains a keyword prefix, else JUNK.
REQ-017 JUNK: delimiter -> IDLE with no stack effect; non-delimiter -> JUNK.
REQ-018 SHALL evaluate only exact keywords (equal length and content); words longer than 7 characters SHALL be JUNK.
REQ-019 "begin" SHALL push type B; "end" SHALL pop and require top type B.
REQ-020 SHALL hold a type stack of DEPTH one-bit entries plus a depth counter.
REQ-021 Pop with depth==0 SHALL set error, err_code=1; depth unchanged.
REQ-022 Pop with top type differing from the closing keyword SHALL set error, err_code=2; depth unchanged.
REQ-023 Push with depth==DEPTH SHALL set error, err_code=3; depth unchanged.
REQ-024 Once error=1, stack, depth and err_code SHALL freeze until reset; the word FSM MAY continue running.
REQ-025 Outputs SHALL update on the edge that accepts the terminating delimiter (latency 1 cycle from delimiter presentation).
REQ-026 Consecutive delimiters SHALL produce empty words with no effect; a trailing word without delimiter SHALL never be evaluated.

Reset
REQ-027 Asserting reset SHALL immediately force FSM=IDLE, depth=0, stack cleared, balanced=1, error=0, err_code=0.
REQ-028 Reset SHALL dominate in_valid on any edge and SHALL discard any partially received word.

Configuration
REQ-029 With macro NEST_CHECKER_CASE_EN defined, "case" SHALL push type C and "endcase" SHALL pop requiring top type C.
REQ-030 Without NEST_CHECKER_CASE_EN, "case" and "endcase" SHALL be JUNK words and the stack SHALL hold only type B; mismatch (err_code=2) SHALL be unreachable.

Verification
REQ-031 Reset, stream "bEgIn EnD " -> depth 1 after 6th char, balanced=1, depth=0 after 10th char.
REQ-032 Stream "end " from reset -> error=1, err_code=1, balanced=0; subsequent "begin end " leaves depth=0, error=1.
REQ-033 DEPTH=2, stream "begin begin begin " -> depth=2, error=1, err_code=3 after final space.
REQ-034 NEST_CHECKER_CASE_EN defined, "case begin endcase " -> err_code=2, depth=2; undefined -> depth=1, error=0.
REQ-035 Stream "beginx endd  begin" with in_valid gaps -> depth=0, balanced=1 (junk words, trailing word unevaluated).
REQ-036 Reset asserted mid-word after "beg" then "in " -> word is JUNK, depth=0, balanced=1.
